// File: rtl/jedro_1_csr_arbiter.sv
// Two-requester round-robin arbiter that turns CSR RW/RS/RC requests into
// read-modify-write sequences on a single-ported CSR file.
module jedro_1_csr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req0_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [1:0]            req0_op_i,
  input  logic [DATA_WIDTH-1:0] req0_wdata_i,
  input  logic                  req1_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [1:0]            req1_op_i,
  input  logic [DATA_WIDTH-1:0] req1_wdata_i,
  output logic                  gnt0_o,
  output logic                  rvalid0_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic                  err0_o,
  output logic                  gnt1_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  err1_o,
  output logic [ADDR_WIDTH-1:0] csr_addr_o,
  output logic                  csr_re_o,
  input  logic [DATA_WIDTH-1:0] csr_rdata_i,
  output logic                  csr_we_o,
  output logic [DATA_WIDTH-1:0] csr_wdata_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_RW  = 2'b00;
  localparam logic [1:0] OP_RS  = 2'b01;
  localparam logic [1:0] OP_RC  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              op_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   old_q;
  logic                    winner_q;
  logic                    last_q;
  logic                    pick;
  logic                    grant;
  logic                    legal;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  assign pick  = (req0_i && req1_i) ? ~last_q : req1_i;
  assign grant = rstn_i && (state_q == IDLE) && (req0_i || req1_i);
  assign legal = (op_q != OP_ILL);
  assign busy_o = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, grant and CSR-file strobes.
  always_comb begin
    state_d     = state_q;
    gnt0_o      = 1'b0;
    gnt1_o      = 1'b0;
    csr_addr_o  = '0;
    csr_re_o    = 1'b0;
    csr_we_o    = 1'b0;
    csr_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          gnt0_o  = ~pick;
          gnt1_o  = pick;
          state_d = READ;
        end
      end
      READ: begin
        csr_addr_o = addr_q;
        csr_re_o   = legal;
        state_d    = WRITE;
      end
      WRITE: begin
        csr_addr_o = addr_q;
        state_d    = RESP;
        case (op_q)
          OP_RW: begin
            csr_wdata_o = wdata_q;
            csr_we_o    = 1'b1;
          end
          OP_RS: begin
            csr_wdata_o = old_q | wdata_q;
            csr_we_o    = |wdata_q;
          end
          OP_RC: begin
            csr_wdata_o = old_q & ~wdata_q;
            csr_we_o    = |wdata_q;
          end
          default: ;
        endcase
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, old-value capture and registered responses.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q    <= '0;
      op_q      <= 2'b00;
      wdata_q   <= '0;
      old_q     <= '0;
      winner_q  <= 1'b0;
      last_q    <= 1'b1;
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
      rdata0_o  <= '0;
      rdata1_o  <= '0;
      err0_o    <= 1'b0;
      err1_o    <= 1'b0;
    end else begin
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
      if (grant) begin
        winner_q <= pick;
        last_q   <= pick;
        addr_q   <= pick ? req1_addr_i  : req0_addr_i;
        op_q     <= pick ? req1_op_i    : req0_op_i;
        wdata_q  <= pick ? req1_wdata_i : req0_wdata_i;
      end
      if (state_q == READ) begin
        old_q <= legal ? csr_rdata_i : '0;
      end
      if (state_q == WRITE) begin
        if (!winner_q) begin
          rvalid0_o <= 1'b1;
          rdata0_o  <= legal ? old_q : '0;
          err0_o    <= ~legal;
        end else begin
          rvalid1_o <= 1'b1;
          rdata1_o  <= legal ? old_q : '0;
          err1_o    <= ~legal;
        end
      end
    end
  end

endmodule

// File: tb/tb_jedro_1_csr_arbiter.sv
// Self-checking bench: the bench owns the CSR file and keeps a reference
// copy of it plus the round-robin history to predict every response.
module tb_jedro_1_csr_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req0, req1;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [1:0]    req0_op, req1_op;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] csr_addr;
  logic          csr_re, csr_we;
  logic [DW-1:0] csr_rdata, csr_wdata;
  logic          busy;

  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_csr [0:4095];
  logic [AW-1:0] addrs   [8];
  logic [DW-1:0] exp_rd  [2];

  int checks = 0;
  int errors = 0;
  int ref_last;

  jedro_1_csr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req0_i(req0), .req0_addr_i(req0_addr), .req0_op_i(req0_op), .req0_wdata_i(req0_wdata),
    .req1_i(req1), .req1_addr_i(req1_addr), .req1_op_i(req1_op), .req1_wdata_i(req1_wdata),
    .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0), .err0_o(err0),
    .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1), .err1_o(err1),
    .csr_addr_o(csr_addr), .csr_re_o(csr_re), .csr_rdata_i(csr_rdata),
    .csr_we_o(csr_we), .csr_wdata_o(csr_wdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Behavioural CSR file: combinational read, write on rising edge.
  assign csr_rdata = mem[csr_addr];
  always @(posedge clk) begin
    if (csr_we) mem[csr_addr] <= csr_wdata;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_new(input logic [1:0] op, input logic [31:0] old,
                                          input logic [31:0] wd);
    case (op)
      2'd0:    return wd;
      2'd1:    return old | wd;
      2'd2:    return old & ~wd;
      default: return 32'd0;
    endcase
  endfunction

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    ref_csr[a] = d;
  endtask

  task automatic rand_req(input int n);
    logic [AW-1:0] a;
    logic [1:0]    op;
    logic [DW-1:0] wd;
    a  = addrs[$urandom_range(0, 7)];
    op = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    wd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    if (n == 0) begin req0 = 1'b1; req0_addr = a; req0_op = op; req0_wdata = wd; end
    else        begin req1 = 1'b1; req1_addr = a; req1_op = op; req1_wdata = wd; end
  endtask

  // Checks the grant in an IDLE cycle whose inputs were just driven.
  task automatic grant_step(output int w, output logic [AW-1:0] a, output logic [1:0] op,
                            output logic [DW-1:0] wd);
    #1;
    if (req0 && req1) w = 1 - ref_last;
    else if (req1)    w = 1;
    else              w = 0;
    check("gnt0", 32'(gnt0), 32'(w == 0));
    check("gnt1", 32'(gnt1), 32'(w == 1));
    check("busy_idle", 32'(busy), 32'd0);
    ref_last = w;
    a  = (w == 1) ? req1_addr  : req0_addr;
    op = (w == 1) ? req1_op    : req0_op;
    wd = (w == 1) ? req1_wdata : req0_wdata;
  endtask

  // Follows a granted transaction through READ, WRITE and RESP.
  task automatic run_txn(input int w, input logic [AW-1:0] a, input logic [1:0] op,
                         input logic [DW-1:0] wd, input bit drop);
    logic [DW-1:0] old, nv;
    bit legal, we;
    legal = (op != 2'd3);
    old   = legal ? ref_csr[a] : 32'd0;
    nv    = exp_new(op, old, wd);
    we    = (op == 2'd0) || (legal && wd != 32'd0);
    @(negedge clk);
    if (drop) begin
      if (w == 0) begin
        req0 = 1'b0; req0_addr = AW'($urandom); req0_op = 2'($urandom); req0_wdata = $urandom;
      end else begin
        req1 = 1'b0; req1_addr = AW'($urandom); req1_op = 2'($urandom); req1_wdata = $urandom;
      end
    end
    #1;
    check("read_re", 32'(csr_re), 32'(legal));
    check("read_addr", 32'(csr_addr), 32'(a));
    check("read_we", 32'(csr_we), 32'd0);
    check("read_busy", 32'(busy), 32'd1);
    check("read_nogrant", 32'({gnt1, gnt0}), 32'd0);
    @(negedge clk); #1;
    check("write_we", 32'(csr_we), 32'(we));
    check("write_addr", 32'(csr_addr), 32'(a));
    check("write_re", 32'(csr_re), 32'd0);
    check("write_nogrant", 32'({gnt1, gnt0}), 32'd0);
    if (we) begin
      check("write_wdata", csr_wdata, nv);
      ref_csr[a] = nv;
    end
    @(negedge clk); #1;
    exp_rd[w] = old;
    check("rvalid_win", 32'((w == 0) ? rvalid0 : rvalid1), 32'd1);
    check("rvalid_other", 32'((w == 0) ? rvalid1 : rvalid0), 32'd0);
    check("rdata", (w == 0) ? rdata0 : rdata1, old);
    check("err", 32'((w == 0) ? err0 : err1), 32'(!legal));
    check("resp_strobes", 32'({csr_re, csr_we}), 32'd0);
    check("resp_addr", 32'(csr_addr), 32'd0);
    check("resp_wdata", csr_wdata, 32'd0);
    check("csr_file", mem[a], ref_csr[a]);
  endtask

  task automatic single(input int n, input logic [AW-1:0] a, input logic [1:0] op,
                        input logic [DW-1:0] wd);
    int w;
    logic [AW-1:0] ga;
    logic [1:0] gop;
    logic [DW-1:0] gwd;
    @(negedge clk);
    if (n == 0) begin req0 = 1'b1; req0_addr = a; req0_op = op; req0_wdata = wd; end
    else        begin req1 = 1'b1; req1_addr = a; req1_op = op; req1_wdata = wd; end
    grant_step(w, ga, gop, gwd);
    run_txn(w, ga, gop, gwd, 1'b1);
  endtask

  initial begin
    int w;
    logic [AW-1:0] ga;
    logic [1:0] gop;
    logic [DW-1:0] gwd;

    rstn = 1'b0;
    req0 = 1'b1; req0_addr = 12'h123; req0_op = 2'd0; req0_wdata = 32'hFFFF_FFFF;
    req1 = 1'b1; req1_addr = 12'h456; req1_op = 2'd1; req1_wdata = 32'h1234_5678;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_err", 32'({err1, err0}), 32'd0);
    check("rst_csr", 32'({csr_re, csr_we, csr_addr}), 32'd0);
    check("rst_wdata", csr_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    poke(12'h340, 32'h3);
    poke(12'h342, 32'h55F);
    poke(12'h100, 32'hABCD);
    for (int i = 0; i < 8; i++) begin
      addrs[i] = AW'(12'h300 + 3 * i);
      poke(addrs[i], $urandom);
    end

    // Both requesters held high from the first cycle after reset.
    @(negedge clk);
    req0 = 1'b1; req0_addr = addrs[0]; req0_op = 2'd0; req0_wdata = 32'hCAFE_0001;
    req1 = 1'b1; req1_addr = addrs[1]; req1_op = 2'd2; req1_wdata = 32'h0000_00F0;
    rstn = 1'b1;
    ref_last = 1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      grant_step(w, ga, gop, gwd);
      check("rr_sequence", 32'(gnt1), 32'(k % 2));
      run_txn(w, ga, gop, gwd, 1'b0);
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("idle_nogrant", 32'({gnt1, gnt0}), 32'd0);
    check("hold_rdata0", rdata0, exp_rd[0]);
    check("hold_rdata1", rdata1, exp_rd[1]);
    check("hold_rvalid", 32'({rvalid1, rvalid0}), 32'd0);

    // Directed RS / RC / zero-operand / illegal-op cases.
    single(0, 12'h340, 2'd1, 32'h55C);
    check("rs_result", mem[12'h340], 32'h55F);
    single(0, 12'h342, 2'd2, 32'h7);
    check("rc_result", mem[12'h342], 32'h558);
    single(1, 12'h100, 2'd1, 32'h0);
    single(1, 12'h100, 2'd3, 32'h0F0F_0F0F);
    check("nowrite_result", mem[12'h100], 32'hABCD);

    // Randomized traffic; the loser keeps its request pending.
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      if (!req0 && $urandom_range(0, 1) == 1) rand_req(0);
      if (!req1 && $urandom_range(0, 1) == 1) rand_req(1);
      if (!req0 && !req1) rand_req(int'($urandom_range(0, 1)));
      grant_step(w, ga, gop, gwd);
      run_txn(w, ga, gop, gwd, 1'b1);
    end

    // Reset in the WRITE cycle of an RW aborts it.
    @(negedge clk);
    req1 = 1'b0;
    req0 = 1'b1; req0_addr = addrs[2]; req0_op = 2'd0; req0_wdata = ~ref_csr[addrs[2]];
    grant_step(w, ga, gop, gwd);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    check("abort_read", 32'(csr_re), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("abort_we", 32'(csr_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    @(negedge clk);
    req0 = 1'b1; req0_addr = addrs[3]; req0_op = 2'd1; req0_wdata = 32'h8000_0001;
    req1 = 1'b1; req1_addr = addrs[4]; req1_op = 2'd0; req1_wdata = 32'h1357_9BDF;
    #1;
    check("abort_csr_file", mem[addrs[2]], ref_csr[addrs[2]]);
    check("abort_no_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
    check("abort_rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    ref_last = 1;
    grant_step(w, ga, gop, gwd);
    check("post_reset_winner", 32'(w), 32'd0);
    run_txn(w, ga, gop, gwd, 1'b1);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jedro_1_csr_arbiter.md
JEDRO_1_CSR_ARBITER -- requirements
Module: jedro_1_csr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, CSR data width.
REQ-002 Parameter ADDR_WIDTH, default 12, CSR address width.
REQ-003 clk_i  input  1  the block's one clock; all state changes on its rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 reqN_i  input  1  access request from requester N (N=0 core pipeline, N=1 debug).
REQ-006 reqN_addr_i  input  ADDR_WIDTH  CSR address from requester N.
REQ-007 reqN_op_i  input  2  requester N operation: 00 RW, 01 RS (set), 10 RC (clear), 11 illegal.
REQ-008 reqN_wdata_i  input  DATA_WIDTH  requester N operand.
REQ-009 gntN_o  output  1  request N accepted this cycle.
REQ-010 rvalidN_o  output  1  one-cycle response strobe to requester N.
REQ-011 rdataN_o  output  DATA_WIDTH  old CSR value returned to requester N.
REQ-012 errN_o  output  1  response to requester N is an error; valid with rvalidN_o.
REQ-013 csr_addr_o  output  ADDR_WIDTH  address to CSR file.
REQ-014 csr_re_o  output  1  CSR file read enable.
REQ-015 csr_rdata_i  input  DATA_WIDTH  CSR file read data, combinational from csr_addr_o.
REQ-016 csr_we_o  output  1  CSR file write enable, sampled by CSR file at next rising edge.
REQ-017 csr_wdata_o  output  DATA_WIDTH  CSR file write data.
REQ-018 busy_o  output  1  high whenever FSM is not IDLE.

Function
REQ-019 FSM states IDLE, READ, WRITE, RESP; exactly one transaction in flight.
REQ-020 IDLE: if any reqN_i high, gntN_o asserted combinationally for exactly one winner; addr/op/wdata/winner latched at that edge; next state READ; else stay IDLE.
REQ-021 Arbitration round-robin: with both requests high, winner is requester not granted last; after reset requester 0 wins the first tie.
REQ-022 Pointer updates only on a grant; a lone requester always wins regardless of pointer.
REQ-023 Non-granted requester holds req/addr/op/wdata stable until its gnt; no gnt outside IDLE.
REQ-024 READ: csr_re_o=1, csr_addr_o=latched addr; csr_rdata_i captured into old value register; next WRITE.
REQ-025 WRITE: csr_addr_o=latched addr; new value RW: wdata; RS: old | wdata; RC: old & ~wdata; next RESP.
REQ-026 WRITE: csr_we_o=1 for RW always; for RS/RC only if wdata != 0 (zero operand reads without side effect).
REQ-027 Op 11: READ and WRITE entered but csr_re_o and csr_we_o stay 0; response carries errN_o=1, rdataN_o=0.
REQ-028 RESP: rvalidN_o=1 for latched winner only, rdataN_o = captured old value, errN_o per REQ-027; next IDLE.
REQ-029 Latency: gnt at cycle T, csr_re_o at T+1, csr_we_o at T+2, rvalid at T+3; back-to-back grant possible at T+4.
REQ-030 rdataN_o/errN_o registered, hold last value between responses; rvalid of non-winner stays 0.
REQ-031 csr_addr_o=0, csr_wdata_o=0, csr_re_o=0, csr_we_o=0 in IDLE and RESP.
REQ-032 Request changes of the in-flight winner after gnt have no effect on the transaction.

Reset
REQ-033 rstn_i low: immediately FSM=IDLE, all outputs 0, old value/latched fields 0, round-robin pointer favours requester 0.
REQ-034 Reset during READ or WRITE aborts: no csr_we_o pulse and no rvalid for the aborted transaction.
REQ-035 First grant possible in the first cycle after rstn_i deasserts.

Verification
REQ-036 CSR 0x340 holds 3; req0 RS wdata 0x55C -> gnt0 at T, rvalid0 at T+3 with rdata0=3, CSR file = 0x55F.
REQ-037 CSR 0x342 holds 0x55F; req0 RC wdata 0x7 -> rdata0=0x55F, csr_wdata_o=0x558 with csr_we_o=1 at T+2.
REQ-038 req0 and req1 both held high continuously after reset -> grants alternate 0,1,0,1 at T, T+4, T+8, T+12.
REQ-039 req1 RS wdata 0 on CSR holding 0xABCD -> rdata1=0xABCD, csr_we_o never asserted; op 11 -> err1=1, rdata1=0, no csr_re_o/csr_we_o.
REQ-040 rstn_i asserted in WRITE cycle of an RW -> csr_we_o=0, no rvalid, busy_o=0; next request granted with requester 0 priority.
